arm_decode_stage: RTL and testbench

- Synchronous ARM instruction decode stage; sits between the issuer (upstream) and the execute/dispatch stage (downstream).
- Requests one instruction at a time, classifies it and extracts its immediate.
- Reads required source registers through a single register-bank read port, then presents instruction, operands and class downstream.
- All three handshakes use a toggle trigger (two-phase request) plus a level ready.

---
 rtl/arm_decode_stage_pkg.sv | 41 ++++
 rtl/arm_decode_stage_if.sv | 35 +++
 rtl/arm_decode_stage_operand.sv | 69 ++++++
 rtl/arm_decode_stage.sv | 164 ++++++++++++++++
 tb/tb_arm_decode_stage.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/arm_decode_stage_pkg.sv
// Shared types for the ARM decode stage: instruction classes, FSM states,
// read-list entries and handshake timing constants.
package arm_decode_stage_pkg;

  localparam int W       = 32;
  localparam int RB_WAIT = 2;
  localparam int WAIT_CW = 4;

  typedef enum logic [3:0] {
    CLS_DP_REG = 4'd0,
    CLS_DP_IMM = 4'd1,
    CLS_LS_IMM = 4'd2,
    CLS_LS_REG = 4'd3,
    CLS_MUL    = 4'd4,
    CLS_BLOCK  = 4'd5,
    CLS_BRANCH = 4'd6,
    CLS_SWI    = 4'd7,
    CLS_UNDEF  = 4'd15
  } cls_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_I,
    ST_DECODE,
    ST_READ,
    ST_VALID
  } state_e;

  // Destination operand of a register read: A=dataOut2, B=dataOut3, C=dataOut4.
  typedef enum logic [1:0] {
    SLOT_A,
    SLOT_B,
    SLOT_C
  } slot_e;

  typedef struct packed {
    logic [3:0] rnum;
    slot_e      slot;
  } rd_entry_t;

endpackage

// File: rtl/arm_decode_stage_if.sv
// Bus bundle for the decode stage: issuer, downstream consumer and register-bank port.
interface arm_decode_stage_if;
  import arm_decode_stage_pkg::*;

  // Every handshake is two-phase: the requester toggles its trigger, the responder
  // drops its ready within one edge, then raises ready with data held stable.
  logic [W-1:0] dataIn;
  logic         readyIn;
  logic         triggerOut;
  logic         triggerIn;
  logic         readyOut;
  logic [W-1:0] dataOut1;
  logic [W-1:0] dataOut2;
  logic [W-1:0] dataOut3;
  logic [W-1:0] dataOut4;
  logic [3:0]   typeOut;
  logic         triggerOutRB;
  logic [W-1:0] addrRB;
  logic         readyInRB;
  logic [W-1:0] dataInRB;
  state_e       state_dbg;

  modport master (
    input  dataIn, readyIn, triggerIn, readyInRB, dataInRB,
    output triggerOut, readyOut, dataOut1, dataOut2, dataOut3, dataOut4,
           typeOut, triggerOutRB, addrRB, state_dbg
  );

  modport slave (
    output dataIn, readyIn, triggerIn, readyInRB, dataInRB,
    input  triggerOut, readyOut, dataOut1, dataOut2, dataOut3, dataOut4,
           typeOut, triggerOutRB, addrRB, state_dbg
  );

endinterface

// File: rtl/arm_decode_stage_operand.sv
// Combinational classifier: instruction class, decoded immediate and the ordered
// list of source registers to fetch (bits [31:28] are condition and not needed).
module arm_decode_operand
  import arm_decode_stage_pkg::*;
(
  input  logic [27:0]         instr,
  output cls_e                cls,
  output logic [W-1:0]        imm,
  output logic [1:0]          rd_cnt,
  output rd_entry_t [2:0]     rd_list
);

  logic [3:0]     rn, rd, rs, rm;
  logic [4:0]     rot;
  logic [2*W-1:0] rot_dbl;

  assign rn      = instr[19:16];
  assign rd      = instr[15:12];
  assign rs      = instr[11:8];
  assign rm      = instr[3:0];
  assign rot     = {instr[11:8], 1'b0};
  assign rot_dbl = {24'd0, instr[7:0], 24'd0, instr[7:0]} >> rot;

  always_comb begin
    cls        = CLS_UNDEF;
    imm        = '0;
    rd_cnt     = 2'd0;
    rd_list[0] = '{rnum: rn, slot: SLOT_A};
    rd_list[1] = '{rnum: rm, slot: SLOT_B};
    rd_list[2] = '{rnum: rs, slot: SLOT_C};
    if (instr[27:22] == 6'd0 && instr[7:4] == 4'b1001) begin
      // Multiply keeps its accumulate/first-source register in [15:12].
      cls             = CLS_MUL;
      rd_cnt          = 2'd3;
      rd_list[0].rnum = rd;
    end else if (instr[27:25] == 3'b000 && instr[7] && instr[4]) begin
      cls = CLS_UNDEF;
    end else if (instr[27:25] == 3'b000) begin
      cls    = CLS_DP_REG;
      rd_cnt = instr[4] ? 2'd3 : 2'd2;
    end else if (instr[27:25] == 3'b001) begin
      cls    = CLS_DP_IMM;
      rd_cnt = 2'd1;
      imm    = rot_dbl[W-1:0];
    end else if (instr[27:25] == 3'b010) begin
      cls        = CLS_LS_IMM;
      rd_cnt     = 2'd2;
      rd_list[1] = '{rnum: rd, slot: SLOT_C};
      imm        = {20'd0, instr[11:0]};
    end else if (instr[27:25] == 3'b011) begin
      if (!instr[4]) begin
        cls        = CLS_LS_REG;
        rd_cnt     = 2'd3;
        rd_list[2] = '{rnum: rd, slot: SLOT_C};
      end
    end else if (instr[27:25] == 3'b100) begin
      cls    = CLS_BLOCK;
      rd_cnt = 2'd1;
      imm    = {16'd0, instr[15:0]};
    end else if (instr[27:25] == 3'b101) begin
      cls = CLS_BRANCH;
      imm = {{6{instr[23]}}, instr[23:0], 2'b00};
    end else if (instr[27:24] == 4'hF) begin
      cls = CLS_SWI;
      imm = {8'd0, instr[23:0]};
    end
  end

endmodule

// File: rtl/arm_decode_stage.sv
// Decode stage: fetches one instruction, classifies it, reads its source registers
// through the single bank port and presents the result until consumed downstream.
module arm_decode_stage
  import arm_decode_stage_pkg::*;
(
  input logic               clk,
  input logic               reset,
  arm_decode_stage_if.master bus
);

  state_e               state_q, state_d;
  logic [W-1:0]         instr_q, instr_d;
  logic [WAIT_CW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [1:0]           rd_idx_q, rd_idx_d;
  logic                 trig_out_q, trig_out_d;
  logic                 trig_rb_q, trig_rb_d;
  logic                 ready_out_q, ready_out_d;
  logic                 prev_trig_in_q, prev_trig_in_d;
  logic [W-1:0]         data_out1_q, data_out1_d;
  logic [W-1:0]         data_out2_q, data_out2_d;
  logic [W-1:0]         data_out3_q, data_out3_d;
  logic [W-1:0]         data_out4_q, data_out4_d;
  logic [3:0]           type_out_q, type_out_d;
  logic [W-1:0]         addr_rb_q, addr_rb_d;

  cls_e                 dec_cls;
  logic [W-1:0]         dec_imm;
  logic [1:0]           dec_cnt;
  rd_entry_t [2:0]      dec_list;
  logic                 wait_done;
  logic [1:0]           next_idx;

  arm_decode_operand u_operand (
    .instr   (instr_q[27:0]),
    .cls     (dec_cls),
    .imm     (dec_imm),
    .rd_cnt  (dec_cnt),
    .rd_list (dec_list)
  );

  // Responder ready is ignored until RB_WAIT edges after our own toggle.
  assign wait_done = (wait_cnt_q >= WAIT_CW'(RB_WAIT - 1));
  assign next_idx  = rd_idx_q + 2'd1;

  always_comb begin
    state_d        = state_q;
    instr_d        = instr_q;
    wait_cnt_d     = wait_done ? wait_cnt_q : wait_cnt_q + 1'b1;
    rd_idx_d       = rd_idx_q;
    trig_out_d     = trig_out_q;
    trig_rb_d      = trig_rb_q;
    ready_out_d    = ready_out_q;
    prev_trig_in_d = bus.triggerIn;
    data_out1_d    = data_out1_q;
    data_out2_d    = data_out2_q;
    data_out3_d    = data_out3_q;
    data_out4_d    = data_out4_q;
    type_out_d     = type_out_q;
    addr_rb_d      = addr_rb_q;
    case (state_q)
      ST_IDLE: begin
        trig_out_d = ~trig_out_q;
        wait_cnt_d = '0;
        state_d    = ST_WAIT_I;
      end
      ST_WAIT_I: begin
        if (wait_done && bus.readyIn) begin
          instr_d = bus.dataIn;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        data_out1_d = instr_q;
        type_out_d  = dec_cls;
        data_out2_d = '0;
        data_out3_d = dec_imm;
        data_out4_d = '0;
        rd_idx_d    = 2'd0;
        if (dec_cnt == 2'd0) begin
          ready_out_d = 1'b1;
          state_d     = ST_VALID;
        end else begin
          addr_rb_d  = {{(W-4){1'b0}}, dec_list[0].rnum};
          trig_rb_d  = ~trig_rb_q;
          wait_cnt_d = '0;
          state_d    = ST_READ;
        end
      end
      ST_READ: begin
        if (wait_done && bus.readyInRB) begin
          case (dec_list[rd_idx_q].slot)
            SLOT_A:  data_out2_d = bus.dataInRB;
            SLOT_B:  data_out3_d = bus.dataInRB;
            default: data_out4_d = bus.dataInRB;
          endcase
          if (next_idx == dec_cnt) begin
            ready_out_d = 1'b1;
            state_d     = ST_VALID;
          end else begin
            rd_idx_d   = next_idx;
            addr_rb_d  = {{(W-4){1'b0}}, dec_list[next_idx].rnum};
            trig_rb_d  = ~trig_rb_q;
            wait_cnt_d = '0;
          end
        end
      end
      ST_VALID: begin
        if (bus.triggerIn != prev_trig_in_q) begin
          ready_out_d = 1'b0;
          trig_out_d  = ~trig_out_q;
          wait_cnt_d  = '0;
          state_d     = ST_WAIT_I;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      instr_q        <= '0;
      wait_cnt_q     <= '0;
      rd_idx_q       <= '0;
      trig_out_q     <= 1'b0;
      trig_rb_q      <= 1'b0;
      ready_out_q    <= 1'b0;
      prev_trig_in_q <= bus.triggerIn;
      data_out1_q    <= '0;
      data_out2_q    <= '0;
      data_out3_q    <= '0;
      data_out4_q    <= '0;
      type_out_q     <= '0;
      addr_rb_q      <= '0;
    end else begin
      state_q        <= state_d;
      instr_q        <= instr_d;
      wait_cnt_q     <= wait_cnt_d;
      rd_idx_q       <= rd_idx_d;
      trig_out_q     <= trig_out_d;
      trig_rb_q      <= trig_rb_d;
      ready_out_q    <= ready_out_d;
      prev_trig_in_q <= prev_trig_in_d;
      data_out1_q    <= data_out1_d;
      data_out2_q    <= data_out2_d;
      data_out3_q    <= data_out3_d;
      data_out4_q    <= data_out4_d;
      type_out_q     <= type_out_d;
      addr_rb_q      <= addr_rb_d;
    end
  end

  assign bus.triggerOut   = trig_out_q;
  assign bus.triggerOutRB = trig_rb_q;
  assign bus.readyOut     = ready_out_q;
  assign bus.dataOut1     = data_out1_q;
  assign bus.dataOut2     = data_out2_q;
  assign bus.dataOut3     = data_out3_q;
  assign bus.dataOut4     = data_out4_q;
  assign bus.typeOut      = type_out_q;
  assign bus.addrRB       = addr_rb_q;
  assign bus.state_dbg    = state_q;

endmodule

// File: tb/tb_arm_decode_stage.sv
// Bench for arm_decode_stage: issuer and register-bank responders with variable
// latency, an instruction-level reference model and directed plus random transactions.
module tb_arm_decode_stage;

  logic clk;
  logic reset;
  arm_decode_stage_if bus ();

  arm_decode_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] regs [16];
  logic [31:0] cur_instr = '0;
  int          iss_lat = 0;
  int          rb_lat  = 0;
  int          to_toggles = 0;
  logic [31:0] obs_rd_q [$];
  logic [31:0] exp_rd_q [$];
  logic [3:0]  exp_cls;
  logic [31:0] exp_a, exp_b, exp_c;

  // Issuer: new instruction after iss_lat idle cycles, garbage while not ready.
  initial begin : issuer
    logic last;
    int   cnt;
    bit   pend;
    bus.readyIn = 1'b0;
    bus.dataIn  = '0;
    last = 1'b0;
    cnt  = 0;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.triggerOut !== last) begin
        last = bus.triggerOut;
        to_toggles++;
        pend = 1'b1;
        cnt  = iss_lat;
        bus.readyIn = 1'b0;
        bus.dataIn  = $urandom;
      end else if (pend) begin
        if (cnt > 0) cnt--;
        else begin
          bus.dataIn  = cur_instr;
          bus.readyIn = 1'b1;
          pend = 1'b0;
        end
      end
    end
  end

  // Register bank: logs every requested address, answers after rb_lat cycles.
  initial begin : reg_bank
    logic        last;
    logic [31:0] addr;
    int          cnt;
    bit          pend;
    bus.readyInRB = 1'b0;
    bus.dataInRB  = '0;
    last = 1'b0;
    addr = '0;
    cnt  = 0;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.triggerOutRB !== last) begin
        last = bus.triggerOutRB;
        addr = bus.addrRB;
        obs_rd_q.push_back(addr);
        pend = 1'b1;
        cnt  = rb_lat;
        bus.readyInRB = 1'b0;
        bus.dataInRB  = $urandom;
      end else if (pend) begin
        if (cnt > 0) cnt--;
        else begin
          bus.dataInRB  = regs[addr[3:0]];
          bus.readyInRB = 1'b1;
          pend = 1'b0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic add_read(input int unsigned n, input int slot);
    exp_rd_q.push_back(32'(n));
    if (slot == 1) exp_a = regs[n];
    else if (slot == 2) exp_b = regs[n];
    else exp_c = regs[n];
  endtask

  // Reference model written directly from the instruction-class rules.
  task automatic model(input logic [31:0] ins);
    int unsigned u, op, rn, rd, rs, rm;
    longint      off;
    u  = ins;
    op = (u >> 25) % 8;
    rn = (u >> 16) % 16;
    rd = (u >> 12) % 16;
    rs = (u >> 8) % 16;
    rm = u % 16;
    exp_cls = 4'd15;
    exp_a = '0;
    exp_b = '0;
    exp_c = '0;
    exp_rd_q.delete();
    if ((u >> 22) % 64 == 0 && (u >> 4) % 16 == 9) begin
      exp_cls = 4'd4;
      add_read(rd, 1); add_read(rm, 2); add_read(rs, 3);
    end else if (op == 0 && (u >> 7) % 2 == 1 && (u >> 4) % 2 == 1) begin
      exp_cls = 4'd15;
    end else if (op == 0) begin
      exp_cls = 4'd0;
      add_read(rn, 1); add_read(rm, 2);
      if ((u >> 4) % 2 == 1) add_read(rs, 3);
    end else if (op == 1) begin
      exp_cls = 4'd1;
      add_read(rn, 1);
      exp_b = u % 256;
      for (int k = 0; k < 2 * rs; k++) exp_b = {exp_b[0], exp_b[31:1]};
    end else if (op == 2) begin
      exp_cls = 4'd2;
      add_read(rn, 1); add_read(rd, 3);
      exp_b = u % 4096;
    end else if (op == 3) begin
      if ((u >> 4) % 2 == 0) begin
        exp_cls = 4'd3;
        add_read(rn, 1); add_read(rm, 2); add_read(rd, 3);
      end
    end else if (op == 4) begin
      exp_cls = 4'd5;
      add_read(rn, 1);
      exp_b = u % 65536;
    end else if (op == 5) begin
      exp_cls = 4'd6;
      off = u % (1 << 24);
      if (off >= (1 << 23)) off = off - (1 << 24);
      exp_b = 32'(off * 4);
    end else if ((u >> 24) % 16 == 15) begin
      exp_cls = 4'd7;
      exp_b = u % (1 << 24);
    end
  endtask

  task automatic prep(input logic [31:0] ins, input int il, input int rl);
    cur_instr = ins;
    iss_lat   = il;
    rb_lat    = rl;
    obs_rd_q.delete();
    to_toggles = 0;
    model(ins);
  endtask

  task automatic finish_txn(input string tag, input int exp_lat);
    int cyc;
    int n;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (bus.readyOut !== 1'b1 && cyc < 400);
    check({tag, ".ready"}, 32'(bus.readyOut), 32'd1);
    if (exp_lat >= 0) check({tag, ".lat"}, cyc, exp_lat);
    check({tag, ".type"}, 32'(bus.typeOut), 32'(exp_cls));
    check({tag, ".d1"}, bus.dataOut1, cur_instr);
    check({tag, ".d2"}, bus.dataOut2, exp_a);
    check({tag, ".d3"}, bus.dataOut3, exp_b);
    check({tag, ".d4"}, bus.dataOut4, exp_c);
    check({tag, ".req"}, to_toggles, 1);
    check({tag, ".nrd"}, obs_rd_q.size(), exp_rd_q.size());
    n = (obs_rd_q.size() < exp_rd_q.size()) ? obs_rd_q.size() : exp_rd_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s.rd%0d", tag, i), obs_rd_q[i], exp_rd_q[i]);
  endtask

  task automatic consume(input string tag, input logic [31:0] ins, input int il, input int rl,
                         input int exp_lat);
    prep(ins, il, rl);
    bus.triggerIn = ~bus.triggerIn;
    finish_txn(tag, exp_lat);
  endtask

  // Consume with handshake checks: drop of readyOut, held outputs, an ignored
  // toggle while not valid, and no spurious consume afterwards.
  task automatic consume_checked(input string tag, input logic [31:0] ins, input int il,
                                 input int rl);
    logic [31:0] old_ins, old_b;
    logic [3:0]  old_cls;
    old_ins = cur_instr;
    old_b   = exp_b;
    old_cls = exp_cls;
    prep(ins, il, rl);
    bus.triggerIn = ~bus.triggerIn;
    @(negedge clk);
    check({tag, ".drop"}, 32'(bus.readyOut), 32'd0);
    check({tag, ".req1"}, to_toggles, 1);
    check({tag, ".hold1"}, bus.dataOut1, old_ins);
    check({tag, ".holdt"}, 32'(bus.typeOut), 32'(old_cls));
    check({tag, ".hold3"}, bus.dataOut3, old_b);
    @(negedge clk);
    bus.triggerIn = ~bus.triggerIn;
    finish_txn(tag, -1);
    repeat (3) @(negedge clk);
    check({tag, ".stay"}, 32'(bus.readyOut), 32'd1);
    check({tag, ".noreq"}, to_toggles, 1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".rdy"}, 32'(bus.readyOut), 32'd0);
    check({tag, ".to"}, 32'(bus.triggerOut), 32'd0);
    check({tag, ".torb"}, 32'(bus.triggerOutRB), 32'd0);
    check({tag, ".addr"}, bus.addrRB, 32'd0);
    check({tag, ".d1"}, bus.dataOut1, 32'd0);
    check({tag, ".d2"}, bus.dataOut2, 32'd0);
    check({tag, ".d3"}, bus.dataOut3, 32'd0);
    check({tag, ".d4"}, bus.dataOut4, 32'd0);
    check({tag, ".type"}, 32'(bus.typeOut), 32'd0);
  endtask

  initial begin : main
    logic [31:0] ins;
    int          cyc;
    for (int i = 0; i < 16; i++) regs[i] = $urandom;
    bus.triggerIn = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("rst");
    #1;
    prep(32'hE0821003, 1, 2);
    reset = 1'b0;
    finish_txn("add", -1);

    consume("dpimm", 32'hE3A014FF, 0, 3, -1);
    consume("branch", 32'hEAFFFFFE, 0, 0, 4);
    consume("ldr", 32'hE5910004, 2, 1, -1);
    consume("mul", 32'hE0000291, 5, 5, -1);
    consume_checked("hs_ldrreg", 32'hE7912003, 5, 5);
    consume_checked("hs_swi", 32'hEF000011, 1, 0);
    consume("dpshift", 32'hE0821312, 3, 2, -1);
    consume("block", 32'hE8BD400F, 0, 4, -1);
    consume("undef_ls", 32'hE7F000F0, 2, 2, -1);
    consume("undef_mx", 32'hE00000B0, 0, 0, -1);

    for (int t = 0; t < 30; t++) begin
      ins = $urandom;
      if (t % 3 == 0) begin
        ins[27:22] = 6'd0;
        ins[7:4]   = 4'b1001;
      end
      consume($sformatf("rnd%0d", t), ins, $urandom_range(0, 5), $urandom_range(0, 5), -1);
    end

    // Reset while a register read is outstanding.
    prep(32'hE0000291, 0, 5);
    bus.triggerIn = ~bus.triggerIn;
    cyc = 0;
    while (obs_rd_q.size() == 0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("midrst.inread", 32'(obs_rd_q.size() > 0), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_zero("midrst");
    #1;
    prep(32'hE0821003, 2, 2);
    reset = 1'b0;
    finish_txn("after_rst", -1);
    consume("final", 32'hE3A014FF, 1, 1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
